// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake game state, apple regeneration and per-pixel colour stage after VGA timing
// Build option: define SNAKE_WRAP_EN so the snake wraps at the grid edges instead of dying there.
module snake_engine #(
  parameter int CELL    = 10,
  parameter int GRID_W  = 51,
  parameter int GRID_H  = 48,
  parameter int MAX_LEN = 16,
  parameter int SPEED   = 6
) (
  input  logic       VGA_clk,
  input  logic       rst,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic       displayArea,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       VGA_R,
  output logic       VGA_G,
  output logic       VGA_B,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int CW = 6;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int FW = $clog2(SPEED);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] XMAX = CW'(GRID_W - 1);
  localparam logic [CW-1:0] YMAX = CW'(GRID_H - 1);

  logic [1:0]    state;
  logic [1:0]    dir;
  logic [1:0]    pendingDir;
  logic [CW-1:0] segX [MAX_LEN];
  logic [CW-1:0] segY [MAX_LEN];
  logic [LW-1:0] len;
  logic [CW-1:0] appleX;
  logic [CW-1:0] appleY;
  logic [15:0]   lfsr;
  logic [FW-1:0] frameCnt;
  logic          moveReq;
  logic          regen;
  logic          pixR, pixG, pixB;

  function automatic logic [CW-1:0] initX(input int i);
    case (i)
      0:       return CW'(25);
      1:       return CW'(24);
      2:       return CW'(23);
      default: return '0;
    endcase
  endfunction

  function automatic logic [CW-1:0] initY(input int i);
    return (i < 3) ? CW'(24) : '0;
  endfunction

  // Up/down and left/right are encoded as pairs differing only in bit 0.
  function automatic logic isOpposite(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b01;
  endfunction

  logic       frameTick;
  logic       anyBtn;
  logic [1:0] btnDir;
  logic [1:0] curDir;

  assign frameTick = (xCount == 10'd0) && (yCount == 10'(GRID_H * CELL));
  assign anyBtn    = btn_up | btn_down | btn_left | btn_right;
  assign curDir    = moveReq ? pendingDir : dir;

  always_comb begin
    btnDir = RIGHT;
    if (btn_up)        btnDir = UP;
    else if (btn_down) btnDir = DOWN;
    else if (btn_left) btnDir = LEFT;
  end

  logic [CW-1:0] newX, newY;
  logic          wallHit;
  logic          selfHit;
  logic          eat;

  always_comb begin
    newX    = segX[0];
    newY    = segY[0];
    wallHit = 1'b0;
    case (pendingDir)
      UP:    if (segY[0] == '0) begin
`ifdef SNAKE_WRAP_EN
               newY = YMAX;
`else
               wallHit = 1'b1;
`endif
             end else newY = segY[0] - ONE;
      DOWN:  if (segY[0] == YMAX) begin
`ifdef SNAKE_WRAP_EN
               newY = '0;
`else
               wallHit = 1'b1;
`endif
             end else newY = segY[0] + ONE;
      LEFT:  if (segX[0] == '0) begin
`ifdef SNAKE_WRAP_EN
               newX = XMAX;
`else
               wallHit = 1'b1;
`endif
             end else newX = segX[0] - ONE;
      default: if (segX[0] == XMAX) begin
`ifdef SNAKE_WRAP_EN
               newX = '0;
`else
               wallHit = 1'b1;
`endif
             end else newX = segX[0] + ONE;
    endcase
  end

  // The tail segment is excluded: it vacates its cell on the same move.
  always_comb begin
    selfHit = 1'b0;
    for (int i = 0; i < MAX_LEN - 1; i++)
      if ((LW'(i + 1) < len) && (segX[i] == newX) && (segY[i] == newY))
        selfHit = 1'b1;
  end

  assign eat = (newX == appleX) && (newY == appleY);

  logic [CW-1:0] candX, candY;
  logic          candOk;

  assign candX = lfsr[5:0];
  assign candY = lfsr[13:8];

  always_comb begin
    candOk = (candX <= XMAX) && (candY <= YMAX);
    for (int i = 0; i < MAX_LEN; i++)
      if ((LW'(i) < len) && (segX[i] == candX) && (segY[i] == candY))
        candOk = 1'b0;
  end

  always_ff @(posedge VGA_clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= LW'(3);
      dir        <= RIGHT;
      pendingDir <= RIGHT;
      appleX     <= CW'(40);
      appleY     <= CW'(10);
      score      <= 8'd0;
      frameCnt   <= '0;
      moveReq    <= 1'b0;
      regen      <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        segX[i] <= initX(i);
        segY[i] <= initY(i);
      end
    end else begin
      case (state)
        IDLE: if (anyBtn && (btnDir != LEFT)) begin
          state      <= RUN;
          dir        <= btnDir;
          pendingDir <= btnDir;
        end
        RUN: begin
          if (anyBtn && !isOpposite(btnDir, curDir)) pendingDir <= btnDir;
          moveReq <= 1'b0;
          if (frameTick) begin
            if (frameCnt == FW'(SPEED - 1)) begin
              frameCnt <= '0;
              moveReq  <= 1'b1;
            end else begin
              frameCnt <= frameCnt + FW'(1);
            end
          end
          if (regen && candOk) begin
            appleX <= candX;
            appleY <= candY;
            regen  <= 1'b0;
          end
          if (moveReq) begin
            dir <= pendingDir;
            if (wallHit || selfHit) begin
              state <= DEAD;
            end else begin
              for (int i = 1; i < MAX_LEN; i++) begin
                segX[i] <= segX[i-1];
                segY[i] <= segY[i-1];
              end
              segX[0] <= newX;
              segY[0] <= newY;
              if (eat) begin
                if (len != LW'(MAX_LEN)) len <= len + LW'(1);
                if (score != 8'hFF) score <= score + 8'd1;
                regen <= 1'b1;
              end
            end
          end
        end
        default: if (anyBtn) begin
          state      <= IDLE;
          len        <= LW'(3);
          dir        <= RIGHT;
          pendingDir <= RIGHT;
          appleX     <= CW'(40);
          appleY     <= CW'(10);
          score      <= 8'd0;
          frameCnt   <= '0;
          moveReq    <= 1'b0;
          regen      <= 1'b0;
          for (int i = 0; i < MAX_LEN; i++) begin
            segX[i] <= initX(i);
            segY[i] <= initY(i);
          end
        end
      endcase
    end
  end

  logic [9:0] cellX, cellY;
  logic       headHit, bodyHit, appleHit;

  assign cellX    = xCount / 10'(CELL);
  assign cellY    = yCount / 10'(CELL);
  assign headHit  = (cellX == 10'(segX[0])) && (cellY == 10'(segY[0]));
  assign appleHit = (cellX == 10'(appleX)) && (cellY == 10'(appleY));

  always_comb begin
    bodyHit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if ((LW'(i) < len) && (cellX == 10'(segX[i])) && (cellY == 10'(segY[i])))
        bodyHit = 1'b1;
  end

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      pixR <= 1'b0;
      pixG <= 1'b0;
      pixB <= 1'b0;
    end else if (state == DEAD) begin
      pixR <= headHit | bodyHit | appleHit;
      pixG <= 1'b0;
      pixB <= 1'b0;
    end else begin
      pixR <= appleHit;
      pixG <= headHit | bodyHit;
      pixB <= headHit;
    end
  end

  assign VGA_R     = pixR & displayArea;
  assign VGA_G     = pixG & displayArea;
  assign VGA_B     = pixB & displayArea;
  assign game_over = (state == DEAD);

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - self-checking bench for snake_engine against a queue-based game model
module tb_snake_engine;

  localparam int MAX_LEN = 16;
  localparam int SPEED   = 6;
  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  logic       VGA_clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] xCount = 10'd600;
  logic [9:0] yCount = 10'd500;
  logic       displayArea = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       VGA_R, VGA_G, VGA_B, game_over;
  logic [7:0] score;

  int nChecks = 0;
  int nFails  = 0;

  always #5 VGA_clk = ~VGA_clk;

  snake_engine dut (
    .VGA_clk(VGA_clk), .rst(rst), .xCount(xCount), .yCount(yCount),
    .displayArea(displayArea), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .game_over(game_over), .score(score)
  );

  // Game model: snake as a queue of cells, head first.
  int bx[$], by[$];
  int ax, ay;
  bit appleKnown, mDead, mRun;
  int mScore, mDir, mPend, mFc;

  function automatic int opp(input int d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  task automatic model_reset();
    bx = {25, 24, 23};
    by = {24, 24, 24};
    ax = 40; ay = 10; appleKnown = 1;
    mDead = 0; mRun = 0; mScore = 0;
    mDir = RIGHT; mPend = RIGHT; mFc = 0;
  endtask

  function automatic logic [2:0] model_color(input int px, input int py);
    int cx, cy;
    bit h, b, a;
    if (px >= 510 || py >= 480) return 3'b000;
    cx = px / 10; cy = py / 10;
    h = (bx[0] == cx) && (by[0] == cy);
    b = 0;
    for (int i = 1; i < bx.size(); i++)
      if (bx[i] == cx && by[i] == cy) b = 1;
    a = appleKnown && (ax == cx) && (ay == cy);
    if (mDead) return {h | b | a, 2'b00};
    return {a, h | b, h};
  endfunction

  task automatic model_move();
    int nx, ny;
    mDir = mPend;
    nx = bx[0] + ((mDir == RIGHT) ? 1 : 0) - ((mDir == LEFT) ? 1 : 0);
    ny = by[0] + ((mDir == DOWN) ? 1 : 0) - ((mDir == UP) ? 1 : 0);
`ifdef SNAKE_WRAP_EN
    nx = (nx + 51) % 51;
    ny = (ny + 48) % 48;
`else
    if (nx < 0 || nx >= 51 || ny < 0 || ny >= 48) begin
      mDead = 1; mRun = 0;
      return;
    end
`endif
    for (int i = 0; i < bx.size() - 1; i++)
      if (bx[i] == nx && by[i] == ny) begin
        mDead = 1; mRun = 0;
        return;
      end
    bx.push_front(nx);
    by.push_front(ny);
    if (appleKnown && nx == ax && ny == ay) begin
      if (mScore < 255) mScore++;
      appleKnown = 0;
      if (bx.size() > MAX_LEN) begin
        void'(bx.pop_back());
        void'(by.pop_back());
      end
    end else begin
      void'(bx.pop_back());
      void'(by.pop_back());
    end
  endtask

  // Per-cycle pixel compare; red is skipped while the apple position is being regenerated.
  logic [2:0] expC;
  bit         rMask;
  int         sx, sy;
  logic [2:0] actC, wantC;

  always @(posedge VGA_clk) begin
    sx = xCount; sy = yCount;
    if (rst) begin expC = 3'b000; rMask = 1; end
    else begin expC = model_color(xCount, yCount); rMask = appleKnown; end
  end

  always @(negedge VGA_clk) begin
    actC  = {VGA_R, VGA_G, VGA_B};
    wantC = rst ? 3'b000 : expC;
    if (!rMask && !rst) begin actC[2] = 1'b0; wantC[2] = 1'b0; end
    nChecks++;
    if (actC !== wantC) begin
      nFails++;
      $display("FAIL pixel x=%0d y=%0d: got rgb=%b want rgb=%b", sx, sy, actC, wantC);
    end
  end

  task automatic chk(input string name, input int act, input int want);
    nChecks++;
    if (act != want) begin
      nFails++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // displayArea lags the coordinates by one cycle, as the timing generator does.
  task automatic drive(input int x, input int y);
    displayArea = (xCount < 10'd510) && (yCount < 10'd480);
    xCount = 10'(x);
    yCount = 10'(y);
  endtask

  task automatic step_pix(input int x, input int y);
    @(posedge VGA_clk); #1;
    drive(x, y);
  endtask

  task automatic lit_px(input string name, input int x, input int y, input logic [2:0] want);
    step_pix(x, y);
    step_pix(600, 500);
    @(negedge VGA_clk);
    chk(name, int'({VGA_R, VGA_G, VGA_B}), int'(want));
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      UP:      btn_up = v;
      DOWN:    btn_down = v;
      LEFT:    btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic pulse(input int which);
    @(posedge VGA_clk); #1; set_btn(which, 1'b1);
    @(posedge VGA_clk); #1; set_btn(which, 1'b0);
    if (mDead) model_reset();
    else if (!mRun) begin
      if (which != LEFT) begin mRun = 1; mDir = which; mPend = which; end
    end else if (which != opp(mDir)) mPend = which;
  endtask

  // Frame tick, then the old head pixel on the two following cycles straddling the move edge.
  task automatic tick();
    bit mv;
    int hx, hy;
    hx = bx[0]; hy = by[0];
    step_pix(0, 480);
    mv = 0;
    if (mRun) begin
      mFc++;
      if (mFc == SPEED) begin mFc = 0; mv = 1; end
    end
    step_pix(hx * 10 + 5, hy * 10 + 5);
    @(posedge VGA_clk); #1;
    if (mv) model_move();
    drive(hx * 10 + 5, hy * 10 + 5);
    step_pix(600, 500);
  endtask

  task automatic find_apple();
    int found, fx, fy;
    bit onSnake;
    found = 0; fx = -1; fy = -1;
    repeat (1000) @(posedge VGA_clk);
    for (int k = 0; k <= 51 * 48; k++) begin
      if (k < 51 * 48) step_pix((k % 51) * 10 + 5, (k / 51) * 10 + 5);
      else step_pix(600, 500);
      @(negedge VGA_clk);
      if (k > 0 && VGA_R === 1'b1) begin
        found++; fx = (k - 1) % 51; fy = (k - 1) / 51;
      end
    end
    chk("new apple cell count", found, 1);
    onSnake = 0;
    for (int i = 0; i < bx.size(); i++)
      if (bx[i] == fx && by[i] == fy) onSnake = 1;
    chk("new apple off snake", int'(onSnake), 0);
    if (found == 1) begin ax = fx; ay = fy; appleKnown = 1; end
  endtask

  task automatic do_move();
    repeat (SPEED) tick();
    if (!appleKnown) find_apple();
  endtask

  task automatic reset_frame_checks(input string tag);
    lit_px({tag, " head corner a"}, 250, 240, 3'b011);
    lit_px({tag, " head corner b"}, 259, 249, 3'b011);
    lit_px({tag, " body left"}, 230, 245, 3'b010);
    lit_px({tag, " body right"}, 249, 245, 3'b010);
    lit_px({tag, " past head"}, 260, 245, 3'b000);
    lit_px({tag, " past tail"}, 229, 245, 3'b000);
    lit_px({tag, " apple a"}, 400, 100, 3'b100);
    lit_px({tag, " apple b"}, 409, 109, 3'b100);
    lit_px({tag, " past apple"}, 410, 105, 3'b000);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hx, hy;
    model_reset();
    repeat (3) @(posedge VGA_clk);
    #1 rst = 1'b0;
    chk("reset score", int'(score), 0);
    chk("reset game_over", int'(game_over), 0);
    reset_frame_checks("reset");

    repeat (3) tick();
    pulse(LEFT);
    repeat (SPEED) tick();
    lit_px("left does not start", 255, 245, 3'b011);

    pulse(UP);
    repeat (SPEED - 1) tick();
    lit_px("no move after 5 ticks", 255, 245, 3'b011);
    tick();
    lit_px("head moved up", 255, 235, 3'b011);
    lit_px("old head is body", 255, 245, 3'b010);
    lit_px("tail vacated", 235, 245, 3'b000);

    repeat (13) do_move();
    lit_px("head at 25,10", 255, 105, 3'b011);
    pulse(RIGHT);
    repeat (15) do_move();
    chk("score after apple", int'(score), 1);
    lit_px("head on eaten apple", 405, 105, 3'b011);
    lit_px("grown tail", 375, 105, 3'b010);

    btn_left = 1'b1;
    repeat (2) do_move();
    btn_left = 1'b0;
    lit_px("reversal ignored", 425, 105, 3'b011);

    repeat (8) do_move();
    lit_px("head at wall column", 505, 105, 3'b011);
    do_move();
`ifdef SNAKE_WRAP_EN
    chk("wrap game_over", int'(game_over), 0);
    lit_px("wrapped head", 5, 105, 3'b011);
    lit_px("old head body after wrap", 505, 105, 3'b010);
`else
    chk("wall game_over", int'(game_over), 1);
    lit_px("dead head red", 505, 105, 3'b100);
    lit_px("dead body red", 495, 105, 3'b100);
    chk("dead score", int'(score), mScore);
    pulse(LEFT);
    chk("restart game_over", int'(game_over), 0);
    chk("restart score", int'(score), 0);
    reset_frame_checks("restart");
`endif

    pulse(UP);
    do_move();
    hx = bx[0] * 10 + 5; hy = by[0] * 10 + 5;
    step_pix(hx, hy);
    step_pix(hx, hy);
    @(negedge VGA_clk);
    chk("head before reset", int'({VGA_R, VGA_G, VGA_B}), 3);
    @(posedge VGA_clk); #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async reset rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    chk("async reset score", int'(score), 0);
    chk("async reset game_over", int'(game_over), 0);
    step_pix(600, 500);
    @(posedge VGA_clk); #1 rst = 1'b0;
    lit_px("head after second reset", 255, 245, 3'b011);
    lit_px("apple after second reset", 405, 105, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
